// File: rtl/main_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : main_fsm_if
//  Brief    : Control bundle between the multicycle FSM and the datapath.
//  Revision : 1.0
// ============================================================================
interface main_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       ALU_op;
  logic [1:0]       ALU_src_a;
  logic [1:0]       ALU_src_b;
  logic [1:0]       result_src;
  logic             adr_src;
  logic             IR_write;
  logic             PC_write;
  logic             reg_write;
  logic             mem_write;
  logic             illegal_instr;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output ALU_op, ALU_src_a, ALU_src_b, result_src, adr_src,
           IR_write, PC_write, reg_write, mem_write, illegal_instr, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALU_op, ALU_src_a, ALU_src_b, result_src, adr_src,
           IR_write, PC_write, reg_write, mem_write, illegal_instr, instret
  );
endinterface
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : main_fsm
//  Brief    : Multicycle RISC-V control FSM with memory stall and instret.
//  Revision : 1.0
// ============================================================================
module main_fsm #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32
) (
  input  wire logic   clk,
  input  wire logic   reset,
  main_fsm_if.master  ctrl_io
);

  localparam logic [6:0] c_op_lw  = 7'b0000011;
  localparam logic [6:0] c_op_sw  = 7'b0100011;
  localparam logic [6:0] c_op_r   = 7'b0110011;
  localparam logic [6:0] c_op_i   = 7'b0010011;
  localparam logic [6:0] c_op_beq = 7'b1100011;
  localparam logic [6:0] c_op_jal = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       w_mem_ready;
  logic [1:0] w_alu_op, w_src_a, w_src_b, w_result_src;
  logic       w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_mem_write;
  logic       w_illegal, w_retire;

  generate
    if (USE_MEM_READY) begin : g_mem_ready
      assign w_mem_ready = ctrl_io.mem_ready;
    end else begin : g_no_mem_ready
      assign w_mem_ready = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    w_alu_op     = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_result_src = 2'b00;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_illegal    = 1'b0;
    w_retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_mem_ready;
        w_pc_write   = w_mem_ready;
        state_d      = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut for BEQ.
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        case (ctrl_io.opcode)
          c_op_lw, c_op_sw: state_d = S_MEMADR;
          c_op_r:           state_d = S_EXECUTER;
          c_op_i:           state_d = S_EXECUTEI;
          c_op_jal:         state_d = S_JAL;
          c_op_beq:         state_d = S_BEQ;
          default: begin
            w_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
        state_d = (ctrl_io.opcode == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        state_d   = w_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = w_mem_ready;
        state_d     = w_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        w_src_a  = 2'b10;
        w_alu_op = 2'b10;
        state_d  = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_src_a  = 2'b10;
        w_src_b  = 2'b01;
        w_alu_op = 2'b10;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BEQ: begin
        w_src_a    = 2'b10;
        w_alu_op   = 2'b01;
        w_pc_write = ctrl_io.zero;
        w_retire   = 1'b1;
      end
      S_JAL: begin
        w_src_a    = 2'b01;
        w_src_b    = 2'b10;
        w_pc_write = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + (w_retire ? CNT_W'(1) : CNT_W'(0));
  end

  assign ctrl_io.ALU_op     = w_alu_op;
  assign ctrl_io.ALU_src_a  = w_src_a;
  assign ctrl_io.ALU_src_b  = w_src_b;
  assign ctrl_io.result_src = w_result_src;
  assign ctrl_io.adr_src    = w_adr_src;
  assign ctrl_io.instret    = instret_q;

  // Reset already forces FETCH asynchronously; only the write strobes need masking.
  assign ctrl_io.IR_write      = w_ir_write  & ~reset;
  assign ctrl_io.PC_write      = w_pc_write  & ~reset;
  assign ctrl_io.reg_write     = w_reg_write & ~reset;
  assign ctrl_io.mem_write     = w_mem_write & ~reset;
  assign ctrl_io.illegal_instr = w_illegal   & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_fsm
//  Brief    : Directed scoreboard bench for main_fsm (stalling and non-stalling).
//  Revision : 1.0
// ============================================================================
module tb_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  typedef enum int {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB, T_BQ, T_JL} tst_e;

  typedef struct packed {
    logic [13:0] sig_a;
    logic [13:0] sig_b;
    logic [3:0]  cnt;
    logic        chk_b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_r = 1'b1;
  logic [6:0] opcode_r = 7'd0;
  logic       zero_r = 1'b0;
  logic       mr_r = 1'b0;
  logic       chk_b = 1'b0;
  logic [3:0] exp_cnt = 4'd0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       q[$];

  main_fsm_if #(.CNT_W(4)) ifa ();
  main_fsm_if #(.CNT_W(4)) ifb ();

  assign ifa.opcode    = opcode_r;
  assign ifa.zero      = zero_r;
  assign ifa.mem_ready = mr_r;
  assign ifb.opcode    = opcode_r;
  assign ifb.zero      = zero_r;
  assign ifb.mem_ready = 1'b0;

  main_fsm #(.USE_MEM_READY(1'b1), .CNT_W(4)) u_dut_a (.clk(clk), .reset(reset_r), .ctrl_io(ifa));
  main_fsm #(.USE_MEM_READY(1'b0), .CNT_W(4)) u_dut_b (.clk(clk), .reset(reset_r), .ctrl_io(ifb));

  always #5 clk = ~clk;

  wire [13:0] sig_a = {ifa.adr_src, ifa.ALU_src_a, ifa.ALU_src_b, ifa.ALU_op, ifa.result_src,
                       ifa.IR_write, ifa.PC_write, ifa.reg_write, ifa.mem_write, ifa.illegal_instr};
  wire [13:0] sig_b = {ifb.adr_src, ifb.ALU_src_a, ifb.ALU_src_b, ifb.ALU_op, ifb.result_src,
                       ifb.IR_write, ifb.PC_write, ifb.reg_write, ifb.mem_write, ifb.illegal_instr};

  // Expected control word per state: {adr, src_a, src_b, op, res, IRw, PCw, RFw, MEMw, ill}
  function automatic logic [13:0] exp_sig(tst_e st, logic mr, logic z, logic [6:0] op);
    logic ill;
    ill = !(op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL);
    case (st)
      T_F:   exp_sig = {1'b0, 2'b00, 2'b10, 2'b00, 2'b10, mr,   mr,   1'b0, 1'b0, 1'b0};
      T_D:   exp_sig = {1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ill};
      T_MA:  exp_sig = {1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      T_MR:  exp_sig = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      T_MWB: exp_sig = {1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      T_MW:  exp_sig = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      T_ER:  exp_sig = {1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      T_EI:  exp_sig = {1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      T_AWB: exp_sig = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      T_BQ:  exp_sig = {1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, z,    1'b0, 1'b0, 1'b0};
      default: exp_sig = {1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic cyc(input tst_e st, input logic mr, input logic z, input logic [6:0] op,
                     input logic rs);
    exp_t e;
    @(posedge clk);
    #1;
    reset_r  = rs;
    mr_r     = mr;
    zero_r   = z;
    opcode_r = op;
    if (rs) exp_cnt = 4'd0;
    e.sig_a = exp_sig(st, mr & ~rs, z, op);
    e.sig_b = exp_sig(st, ~rs, z, op);
    e.cnt   = exp_cnt;
    e.chk_b = chk_b;
    q.push_back(e);
    if (!rs && (st == T_MWB || st == T_AWB || st == T_BQ || (st == T_MW && mr)))
      exp_cnt = exp_cnt + 4'd1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (sig_a !== e.sig_a) begin
        n_fail++;
        $display("FAIL ctrl_a t=%0t actual=%b required=%b", $time, sig_a, e.sig_a);
      end
      n_chk++;
      if (ifa.instret !== e.cnt) begin
        n_fail++;
        $display("FAIL instret_a t=%0t actual=%0d required=%0d", $time, ifa.instret, e.cnt);
      end
      if (e.chk_b) begin
        n_chk++;
        if (sig_b !== e.sig_b) begin
          n_fail++;
          $display("FAIL ctrl_b t=%0t actual=%b required=%b", $time, sig_b, e.sig_b);
        end
        n_chk++;
        if (ifb.instret !== e.cnt) begin
          n_fail++;
          $display("FAIL instret_b t=%0t actual=%0d required=%0d", $time, ifb.instret, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin
    cyc(T_F, 1'b1, 1'b0, BAD, 1'b1);
    cyc(T_F, 1'b1, 1'b0, BAD, 1'b1);
    // lw with two stall cycles in FETCH and in MEMREAD
    cyc(T_F, 1'b0, 1'b0, LW, 1'b0);  cyc(T_F, 1'b0, 1'b0, LW, 1'b0);
    cyc(T_F, 1'b1, 1'b0, LW, 1'b0);  cyc(T_D, 1'b1, 1'b0, LW, 1'b0);
    cyc(T_MA, 1'b1, 1'b0, LW, 1'b0); cyc(T_MR, 1'b0, 1'b0, LW, 1'b0);
    cyc(T_MR, 1'b0, 1'b0, LW, 1'b0); cyc(T_MR, 1'b1, 1'b0, LW, 1'b0);
    cyc(T_MWB, 1'b1, 1'b0, LW, 1'b0);
    // sw holding mem_write across one stall cycle
    cyc(T_F, 1'b1, 1'b0, SW, 1'b0);  cyc(T_D, 1'b1, 1'b0, SW, 1'b0);
    cyc(T_MA, 1'b1, 1'b0, SW, 1'b0); cyc(T_MW, 1'b0, 1'b0, SW, 1'b0);
    cyc(T_MW, 1'b1, 1'b0, SW, 1'b0);
    // beq taken then not taken
    cyc(T_F, 1'b1, 1'b1, BQ, 1'b0);  cyc(T_D, 1'b1, 1'b1, BQ, 1'b0);
    cyc(T_BQ, 1'b1, 1'b1, BQ, 1'b0);
    cyc(T_F, 1'b1, 1'b0, BQ, 1'b0);  cyc(T_D, 1'b1, 1'b0, BQ, 1'b0);
    cyc(T_BQ, 1'b1, 1'b0, BQ, 1'b0);
    // R, I, jal
    cyc(T_F, 1'b1, 1'b0, RT, 1'b0);  cyc(T_D, 1'b1, 1'b0, RT, 1'b0);
    cyc(T_ER, 1'b1, 1'b0, RT, 1'b0); cyc(T_AWB, 1'b1, 1'b0, RT, 1'b0);
    cyc(T_F, 1'b1, 1'b0, IT, 1'b0);  cyc(T_D, 1'b1, 1'b0, IT, 1'b0);
    cyc(T_EI, 1'b1, 1'b0, IT, 1'b0); cyc(T_AWB, 1'b1, 1'b0, IT, 1'b0);
    cyc(T_F, 1'b1, 1'b0, JL, 1'b0);  cyc(T_D, 1'b1, 1'b0, JL, 1'b0);
    cyc(T_JL, 1'b1, 1'b0, JL, 1'b0); cyc(T_AWB, 1'b1, 1'b0, JL, 1'b0);
    // illegal opcode: pulse in DECODE, not retired
    cyc(T_F, 1'b1, 1'b0, BAD, 1'b0); cyc(T_D, 1'b1, 1'b0, BAD, 1'b0);
    // nine beqs take instret 7 -> 15 -> 0 (CNT_W=4 wrap)
    for (int i = 0; i < 9; i++) begin
      cyc(T_F, 1'b1, 1'b0, BQ, 1'b0); cyc(T_D, 1'b1, 1'b0, BQ, 1'b0);
      cyc(T_BQ, 1'b1, 1'b0, BQ, 1'b0);
    end
    cyc(T_F, 1'b1, 1'b0, BQ, 1'b0);  cyc(T_D, 1'b1, 1'b0, BQ, 1'b0);
    cyc(T_BQ, 1'b1, 1'b0, BQ, 1'b0);
    // reset in the middle of a stalled MEMWRITE
    cyc(T_F, 1'b1, 1'b0, SW, 1'b0);  cyc(T_D, 1'b1, 1'b0, SW, 1'b0);
    cyc(T_MA, 1'b1, 1'b0, SW, 1'b0); cyc(T_MW, 1'b0, 1'b0, SW, 1'b0);
    chk_b = 1'b1;
    cyc(T_F, 1'b1, 1'b0, SW, 1'b1);
    // both instances now in lockstep; B ignores its tied-low mem_ready
    cyc(T_F, 1'b1, 1'b0, LW, 1'b0);  cyc(T_D, 1'b1, 1'b0, LW, 1'b0);
    cyc(T_MA, 1'b1, 1'b0, LW, 1'b0); cyc(T_MR, 1'b1, 1'b0, LW, 1'b0);
    cyc(T_MWB, 1'b1, 1'b0, LW, 1'b0);
    cyc(T_F, 1'b1, 1'b0, SW, 1'b0);  cyc(T_D, 1'b1, 1'b0, SW, 1'b0);
    cyc(T_MA, 1'b1, 1'b0, SW, 1'b0); cyc(T_MW, 1'b1, 1'b0, SW, 1'b0);
    cyc(T_F, 1'b1, 1'b0, RT, 1'b0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
